// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer block: register indices, CTRL/STATUS
// bit positions, reset values and a byte-lane merge helper.
package timer_defs;

  typedef enum logic [2:0] {
    TIMER_REG_CTRL     = 3'd0,
    TIMER_REG_PRESCALE = 3'd1,
    TIMER_REG_COUNT    = 3'd2,
    TIMER_REG_COMPARE  = 3'd3,
    TIMER_REG_STATUS   = 3'd4,
    TIMER_REG_DUTY     = 3'd5,
    TIMER_REG_RSVD6    = 3'd6,
    TIMER_REG_RSVD7    = 3'd7
  } timer_reg_e;

  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IE          = 2;
  localparam int unsigned STATUS_MATCH     = 0;

  localparam logic [2:0]  CTRL_RESET   = '0;
  localparam logic [31:0] COUNT_RESET  = '0;
  localparam logic [31:0] DUTY_RESET   = '0;
  localparam logic        MATCH_RESET  = 1'b0;

  // Replace only the bytes whose write enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler for bus_timer: counts 0..prescale_i while enabled and emits a
// one-cycle tick when the count equals prescale_i.
module timer_prescaler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] prescale_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] pre_cnt_q, pre_cnt_d;

  assign tick_o = enable_i & (pre_cnt_q == prescale_i);

  // Next prescaler count: held at 0 when disabled or cleared, wraps on tick.
  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (!enable_i || clear_i || tick_o) pre_cnt_d = '0;
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt_q <= '0;
    else        pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 32-bit prescaled timer with compare match,
// one-shot/auto-reload, sticky MATCH and level interrupt.
// Optional PWM output and DUTY register enabled by macro TIMER_PWM_EN.
module bus_timer
  import timer_defs::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter logic [31:0] COMPARE_RESET  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  timer_address,
  input  logic [31:0] timer_data_i,
  input  logic [3:0]  timer_wr,
  input  logic        timer_enable,
  output logic [31:0] timer_data_o,
  output logic        timer_ready,
  output logic        timer_interrupt
`ifdef TIMER_PWM_EN
  ,
  output logic        timer_pwm
`endif
);

  logic [2:0]                ctrl_q, ctrl_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [31:0]               count_q, count_d;
  logic [31:0]               compare_q, compare_d;
  logic                      match_q, match_d;
  logic                      ready_q, ready_d;
  logic [31:0]               rdata_q, rdata_d;
`ifdef TIMER_PWM_EN
  logic [31:0]               duty_q, duty_d;
  logic                      pwm_q, pwm_d;
`endif

  logic       accept, wr_any, tick, match_evt;
  logic       we_ctrl, we_prescale, we_count, we_compare, we_status;
  logic [31:0] prescale_m;
  timer_reg_e reg_sel;
  logic       unused_bits;

  assign reg_sel     = timer_reg_e'(timer_address[4:2]);
  assign accept      = timer_enable & ~ready_q;
  assign wr_any      = |timer_wr;
  assign we_ctrl     = accept & wr_any & (reg_sel == TIMER_REG_CTRL);
  assign we_prescale = accept & wr_any & (reg_sel == TIMER_REG_PRESCALE);
  assign we_count    = accept & wr_any & (reg_sel == TIMER_REG_COUNT);
  assign we_compare  = accept & wr_any & (reg_sel == TIMER_REG_COMPARE);
  assign we_status   = accept & wr_any & (reg_sel == TIMER_REG_STATUS);

  // A bus write to COUNT overrides the tick, so no match is evaluated then.
  assign match_evt   = tick & ~we_count & (count_q == compare_q);

  assign timer_ready     = ready_q;
  assign timer_data_o    = rdata_q;
  assign timer_interrupt = match_q & ctrl_q[CTRL_IE];
`ifdef TIMER_PWM_EN
  assign timer_pwm       = pwm_q;
`endif

  assign unused_bits = ^{timer_address[1:0], prescale_m};

  timer_prescaler #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (ctrl_q[CTRL_EN]),
    .clear_i    (we_count | we_prescale),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  // Next-state for registers, counter, handshake and read data.
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_m = merge_bytes(32'(prescale_q), timer_data_i, timer_wr);
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;
    ready_d    = timer_enable & ~ready_q;
    rdata_d    = '0;
`ifdef TIMER_PWM_EN
    duty_d     = duty_q;
    pwm_d      = ctrl_q[CTRL_EN] & (count_q < duty_q);
`endif

    if (tick) begin
      count_d = match_evt ? '0 : count_q + 32'd1;
    end
    if (match_evt && !ctrl_q[CTRL_AUTO_RELOAD]) ctrl_d[CTRL_EN] = 1'b0;

    if (we_ctrl && timer_wr[0]) ctrl_d = timer_data_i[2:0];
    if (we_prescale)            prescale_d = prescale_m[PRESCALE_WIDTH-1:0];
    if (we_count)               count_d = merge_bytes(count_q, timer_data_i, timer_wr);
    if (we_compare)             compare_d = merge_bytes(compare_q, timer_data_i, timer_wr);
`ifdef TIMER_PWM_EN
    if (accept && wr_any && reg_sel == TIMER_REG_DUTY)
      duty_d = merge_bytes(duty_q, timer_data_i, timer_wr);
`endif

    // Set has priority over write-1-to-clear.
    if (we_status && timer_wr[0] && timer_data_i[STATUS_MATCH]) match_d = 1'b0;
    if (match_evt) match_d = 1'b1;

    if (accept && !wr_any) begin
      case (reg_sel)
        TIMER_REG_CTRL:     rdata_d = {29'd0, ctrl_q};
        TIMER_REG_PRESCALE: rdata_d = 32'(prescale_q);
        TIMER_REG_COUNT:    rdata_d = count_q;
        TIMER_REG_COMPARE:  rdata_d = compare_q;
        TIMER_REG_STATUS:   rdata_d = {31'd0, match_q};
`ifdef TIMER_PWM_EN
        TIMER_REG_DUTY:     rdata_d = duty_q;
`endif
        default:            rdata_d = '0;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_RESET;
      prescale_q <= '0;
      count_q    <= COUNT_RESET;
      compare_q  <= COMPARE_RESET;
      match_q    <= MATCH_RESET;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
`ifdef TIMER_PWM_EN
      duty_q     <= DUTY_RESET;
      pwm_q      <= 1'b0;
`endif
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
`ifdef TIMER_PWM_EN
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer (PWM checks with TIMER_PWM_EN).
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  timer_address = '0;
  logic [31:0] timer_data_i = '0;
  logic [3:0]  timer_wr = '0;
  logic        timer_enable = 1'b0;
  logic [31:0] timer_data_o;
  logic        timer_ready;
  logic        timer_interrupt;
`ifdef TIMER_PWM_EN
  logic        timer_pwm;
`endif

  int n_chk = 0;
  int n_fail = 0;

  bus_timer #(
    .PRESCALE_WIDTH (16),
    .COMPARE_RESET  (32'hFFFF_FFFF)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .timer_address   (timer_address),
    .timer_data_i    (timer_data_i),
    .timer_wr        (timer_wr),
    .timer_enable    (timer_enable),
    .timer_data_o    (timer_data_o),
    .timer_ready     (timer_ready),
    .timer_interrupt (timer_interrupt)
`ifdef TIMER_PWM_EN
    ,
    .timer_pwm       (timer_pwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    timer_enable  = 1'b1;
    timer_address = {idx, 2'b00};
    timer_data_i  = d;
    timer_wr      = be;
    @(posedge clk);
    @(negedge clk);
    timer_enable  = 1'b0;
    timer_wr      = '0;
  endtask

  task automatic bus_rd(input logic [2:0] idx, input bit chk_rdy, output logic [31:0] d);
    @(negedge clk);
    timer_enable  = 1'b1;
    timer_address = {idx, 2'b00};
    timer_wr      = '0;
    if (chk_rdy) chk("rdy_pre", {31'd0, timer_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (chk_rdy) chk("rdy_ack", {31'd0, timer_ready}, 32'd1);
    d = timer_data_o;
    timer_enable = 1'b0;
  endtask

  task automatic wait_irq(output int cyc);
    cyc = 0;
    while (!timer_interrupt && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] exp_rst [8];
    int cyc;
    exp_rst = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, timer_ready}, 32'd0);
    chk("rst_data", timer_data_o, 32'd0);
    chk("rst_irq", {31'd0, timer_interrupt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values of every address, and ready exactly one cycle wide
    for (int i = 0; i < 8; i++) begin
      bus_rd(3'(i), 1'b1, d);
      chk($sformatf("rst_reg%0d", i), d, exp_rst[i]);
      @(posedge clk);
      #1;
      chk("rdy_fall", {31'd0, timer_ready}, 32'd0);
    end

    // Prescaled auto-reload with interrupt: 6 ticks x 4 clocks
    bus_wr(3'd1, 32'd3, 4'hF);
    bus_wr(3'd3, 32'd5, 4'hF);
    bus_wr(3'd0, 32'd7, 4'hF);
    wait_irq(cyc);
    chk("ar_match_cycles", 32'(cyc), 32'd24);
    bus_rd(3'd2, 1'b0, d);
    chk("ar_count_reload", d, 32'd0);
    bus_rd(3'd0, 1'b0, d);
    chk("ar_ctrl_kept", d, 32'd7);
    bus_rd(3'd4, 1'b0, d);
    chk("ar_status", d, 32'd1);
    bus_wr(3'd4, 32'd1, 4'hF);
    chk("ar_irq_clear", {31'd0, timer_interrupt}, 32'd0);
    bus_wr(3'd0, 32'd0, 4'hF);

    // One-shot
    bus_wr(3'd2, 32'd0, 4'hF);
    bus_wr(3'd1, 32'd0, 4'hF);
    bus_wr(3'd3, 32'd2, 4'hF);
    bus_wr(3'd0, 32'd5, 4'hF);
    wait_irq(cyc);
    chk("os_match_cycles", 32'(cyc), 32'd3);
    bus_rd(3'd0, 1'b0, d);
    chk("os_en_cleared", d, 32'd4);
    repeat (4) @(posedge clk);
    bus_rd(3'd2, 1'b0, d);
    chk("os_count_held", d, 32'd0);
    bus_wr(3'd4, 32'd1, 4'hF);
    chk("os_irq_clear", {31'd0, timer_interrupt}, 32'd0);

    // Byte-lane writes
    bus_wr(3'd3, 32'd0, 4'hF);
    bus_wr(3'd3, 32'hAABB_CCDD, 4'b0101);
    bus_rd(3'd3, 1'b0, d);
    chk("byte_compare", d, 32'h00BB_00DD);

    // Reserved address writes are ignored
    bus_wr(3'd6, 32'h1234_5678, 4'hF);
    bus_rd(3'd6, 1'b0, d);
    chk("rsvd6_read", d, 32'd0);

    // W1C in the same cycle as a match: set wins
    bus_wr(3'd0, 32'd0, 4'hF);
    bus_wr(3'd2, 32'd0, 4'hF);
    bus_wr(3'd3, 32'd3, 4'hF);
    bus_wr(3'd0, 32'd3, 4'hF);       // EN+AR accepted at E0, match at E4
    bus_rd(3'd2, 1'b0, d);           // accepted at E2
    chk("col_count_e2", d, 32'd1);
    bus_wr(3'd4, 32'd1, 4'hF);       // accepted at E4, same edge as match
    bus_rd(3'd4, 1'b0, d);
    chk("col_w1c_vs_match", d, 32'd1);
    bus_wr(3'd0, 32'd0, 4'hF);
    bus_wr(3'd4, 32'd1, 4'hF);

    // COUNT write in a tick cycle: bus value wins
    bus_wr(3'd2, 32'd0, 4'hF);
    bus_wr(3'd3, 32'h100, 4'hF);
    bus_wr(3'd1, 32'd3, 4'hF);
    bus_wr(3'd0, 32'd1, 4'hF);       // EN at E0, first tick at E4
    bus_rd(3'd2, 1'b0, d);
    chk("cw_count_e2", d, 32'd0);
    bus_wr(3'd2, 32'h10, 4'hF);      // accepted at E4 (tick edge)
    bus_rd(3'd2, 1'b0, d);
    chk("cw_count_win", d, 32'h10);
    bus_wr(3'd0, 32'd0, 4'hF);

`ifdef TIMER_PWM_EN
    // PWM: period 10, high 3
    bus_wr(3'd2, 32'd0, 4'hF);
    bus_wr(3'd3, 32'd9, 4'hF);
    bus_wr(3'd5, 32'd3, 4'hF);
    bus_wr(3'd1, 32'd0, 4'hF);
    bus_wr(3'd0, 32'd3, 4'hF);
    bus_rd(3'd5, 1'b0, d);
    chk("pwm_duty_read", d, 32'd3);
    repeat (5) @(negedge clk);
    begin
      int highs = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        highs += int'(timer_pwm);
      end
      chk("pwm_high_count", 32'(highs), 32'd6);
    end
    begin
      int w = 0;
      while (!timer_pwm && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("pwm_found_high", {31'd0, timer_pwm}, 32'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("pwm_async_rst", {31'd0, timer_pwm}, 32'd0);
    chk("pwm_rst_ready", {31'd0, timer_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Async reset in the middle of an access
    @(negedge clk);
    timer_enable  = 1'b1;
    timer_address = {3'd3, 2'b00};
    timer_wr      = '0;
    @(posedge clk);
    #1;
    chk("mid_ready_hi", {31'd0, timer_ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, timer_ready}, 32'd0);
    chk("mid_rst_data", timer_data_o, 32'd0);
    @(negedge clk);
    timer_enable = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_no_ready", {31'd0, timer_ready}, 32'd0);
    bus_rd(3'd3, 1'b0, d);
    chk("post_rst_compare", d, 32'hFFFF_FFFF);
    bus_rd(3'd0, 1'b0, d);
    chk("post_rst_ctrl", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
